// File: rtl/uop_sequencer.sv
// uop_sequencer: fetch-to-decode micro-op sequencer; expands LDM/STM into per-register uops.
// Define UOPSEQ_WB_UOP_EN to emit base writeback as its own uop; by default it is folded into the last transfer.
module uop_sequencer #(
   parameter int REG_COUNT = 16,
   parameter int ADDR_STEP = 4,
   parameter int OFF_W     = $clog2(REG_COUNT*ADDR_STEP)+2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic                    instr_valid,
   input  logic [31:0]             instr,
   output logic                    instr_ready,
   output logic                    uop_valid,
   input  logic                    uop_ready,
   output logic [31:0]             uop_instr,
   output logic [1:0]              uop_kind,
   output logic [3:0]              uop_rd,
   output logic signed [OFF_W-1:0] uop_offset,
   output logic                    uop_last,
   output logic                    uop_wb,
   output logic                    busy
);

   // state  | meaning
   // IDLE   | no sequence pending; output stage holds a single-uop instr or is empty
   // SEQ    | output stage holds a transfer uop of a block sequence
   // WB     | output stage holds the writeback uop (UOPSEQ_WB_UOP_EN only)
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef UOPSEQ_WB_UOP_EN
      S_WB   = 2'd2,
`endif
      S_SEQ  = 2'd1
   } state_t;

   localparam logic [1:0] K_PASS = 2'b00;
   localparam logic [1:0] K_XFER = 2'b01;
   localparam logic [1:0] K_NOP  = 2'b11;
`ifdef UOPSEQ_WB_UOP_EN
   localparam logic [1:0] K_WB   = 2'b10;
`endif
   localparam logic [OFF_W-1:0] STEP = OFF_W'(ADDR_STEP);

   function automatic logic [3:0] pri_enc(input logic [REG_COUNT-1:0] l);
      logic [3:0] r;
      r = '0;
      for (int i = REG_COUNT-1; i >= 0; i--) begin
         if (l[i]) r = 4'(i);
      end
      return r;
   endfunction

   function automatic logic [REG_COUNT-1:0] clr_low(input logic [REG_COUNT-1:0] l);
      return l & ~(REG_COUNT'(1) << pri_enc(l));
   endfunction

   function automatic logic [OFF_W-1:0] popcnt(input logic [REG_COUNT-1:0] l);
      logic [OFF_W-1:0] c;
      c = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         c = c + {{(OFF_W-1){1'b0}}, l[i]};
      end
      return c;
   endfunction

   state_t                 state_q, state_d;
   logic [REG_COUNT-1:0]   mask_q, mask_d;
   logic [OFF_W-1:0]       off_q, off_d;
   logic                   w_q, w_d;
`ifdef UOPSEQ_WB_UOP_EN
   logic [OFF_W-1:0]       wbo_q, wbo_d;
`endif
   logic                   uop_valid_q, uop_valid_d;
   logic [31:0]            uop_instr_q, uop_instr_d;
   logic [1:0]             uop_kind_q, uop_kind_d;
   logic [3:0]             uop_rd_q, uop_rd_d;
   logic [OFF_W-1:0]       uop_offset_q, uop_offset_d;
   logic                   uop_last_q, uop_last_d;
   logic                   uop_wb_q, uop_wb_d;

   logic                   is_blk, bit_p, bit_u, bit_w;
   logic [REG_COUNT-1:0]   list, list_rest, mask_rest;
   logic [OFF_W-1:0]       n_cnt, nstep, base_off;
   logic                   adv, take;

   assign is_blk    = (instr[27:25] == 3'b100);
   assign bit_p     = instr[24];
   assign bit_u     = instr[23];
   assign bit_w     = instr[21];
   assign list      = instr[REG_COUNT-1:0];
   assign list_rest = clr_low(list);
   assign mask_rest = clr_low(mask_q);
   assign n_cnt     = popcnt(list);
   assign nstep     = n_cnt * STEP;

   // Offsets of transfer 0 for IA / IB / DA / DB; later transfers add STEP each.
   always_comb begin
      base_off = '0;
      case ({bit_p, bit_u})
         2'b01:   base_off = '0;
         2'b11:   base_off = STEP;
         2'b00:   base_off = STEP - nstep;
         default: base_off = '0 - nstep;
      endcase
   end

   assign adv         = ~uop_valid_q | uop_ready;
   assign take        = uop_valid_q & uop_ready;
   assign instr_ready = (state_q == S_IDLE) & adv & ~flush;

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      off_d        = off_q;
      w_d          = w_q;
`ifdef UOPSEQ_WB_UOP_EN
      wbo_d        = wbo_q;
`endif
      uop_valid_d  = uop_valid_q;
      uop_instr_d  = uop_instr_q;
      uop_kind_d   = uop_kind_q;
      uop_rd_d     = uop_rd_q;
      uop_offset_d = uop_offset_q;
      uop_last_d   = uop_last_q;
      uop_wb_d     = uop_wb_q;

      if (flush) begin
         state_d     = S_IDLE;
         uop_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (adv) begin
                  uop_valid_d = instr_valid;
                  if (instr_valid) begin
                     uop_instr_d  = instr;
                     uop_offset_d = '0;
                     uop_wb_d     = 1'b0;
                     uop_last_d   = 1'b1;
                     if (!is_blk) begin
                        uop_kind_d = K_PASS;
                        uop_rd_d   = instr[15:12];
                     end else if (n_cnt == '0) begin
                        uop_kind_d = K_NOP;
                        uop_rd_d   = '0;
                     end else begin
                        uop_kind_d   = K_XFER;
                        uop_rd_d     = pri_enc(list);
                        uop_offset_d = base_off;
                        mask_d       = list_rest;
                        off_d        = base_off + STEP;
                        w_d          = bit_w;
`ifdef UOPSEQ_WB_UOP_EN
                        wbo_d        = bit_u ? nstep : ('0 - nstep);
                        uop_last_d   = (list_rest == '0) & ~bit_w;
`else
                        uop_last_d   = (list_rest == '0);
                        uop_wb_d     = (list_rest == '0) & bit_w;
`endif
                        if ((list_rest != '0) || bit_w) state_d = S_SEQ;
                     end
                  end
               end
            end
            S_SEQ: begin
               if (take) begin
                  if (uop_last_q) begin
                     state_d     = S_IDLE;
                     uop_valid_d = 1'b0;
                  end else if (mask_q != '0) begin
                     uop_kind_d   = K_XFER;
                     uop_rd_d     = pri_enc(mask_q);
                     uop_offset_d = off_q;
                     off_d        = off_q + STEP;
                     mask_d       = mask_rest;
`ifdef UOPSEQ_WB_UOP_EN
                     uop_last_d   = (mask_rest == '0) & ~w_q;
`else
                     uop_last_d   = (mask_rest == '0);
                     uop_wb_d     = (mask_rest == '0) & w_q;
`endif
                  end
`ifdef UOPSEQ_WB_UOP_EN
                  else begin
                     state_d      = S_WB;
                     uop_kind_d   = K_WB;
                     uop_rd_d     = '0;
                     uop_offset_d = wbo_q;
                     uop_last_d   = 1'b1;
                  end
`endif
               end
            end
`ifdef UOPSEQ_WB_UOP_EN
            S_WB: begin
               if (take) begin
                  state_d     = S_IDLE;
                  uop_valid_d = 1'b0;
               end
            end
`endif
            default: begin
               state_d     = S_IDLE;
               uop_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         mask_q       <= '0;
         off_q        <= '0;
         w_q          <= 1'b0;
`ifdef UOPSEQ_WB_UOP_EN
         wbo_q        <= '0;
`endif
         uop_valid_q  <= 1'b0;
         uop_instr_q  <= '0;
         uop_kind_q   <= '0;
         uop_rd_q     <= '0;
         uop_offset_q <= '0;
         uop_last_q   <= 1'b0;
         uop_wb_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         off_q        <= off_d;
         w_q          <= w_d;
`ifdef UOPSEQ_WB_UOP_EN
         wbo_q        <= wbo_d;
`endif
         uop_valid_q  <= uop_valid_d;
         uop_instr_q  <= uop_instr_d;
         uop_kind_q   <= uop_kind_d;
         uop_rd_q     <= uop_rd_d;
         uop_offset_q <= uop_offset_d;
         uop_last_q   <= uop_last_d;
         uop_wb_q     <= uop_wb_d;
      end
   end

   assign uop_valid  = uop_valid_q;
   assign uop_instr  = uop_instr_q;
   assign uop_kind   = uop_kind_q;
   assign uop_rd     = uop_rd_q;
   assign uop_offset = uop_offset_q;
   assign uop_last   = uop_last_q;
   assign uop_wb     = uop_wb_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: directed instructions push hand-computed uops; a monitor pops on each handshake.
module tb_uop_sequencer;
   localparam int OFF_W = 8;
   localparam logic [31:0] LDMIA = 32'hE8B0002A;
   localparam logic [31:0] STMDB = 32'hE92D4010;
   localparam logic [31:0] ADD   = 32'hE0811002;
   localparam logic [31:0] EMPTY = 32'hE8900000;
   localparam logic [31:0] MOV   = 32'hE3A0200F;

   logic                    clk, reset_n, flush, instr_valid, instr_ready;
   logic [31:0]             instr, uop_instr;
   logic                    uop_valid, uop_ready, uop_last, uop_wb, busy;
   logic [1:0]              uop_kind;
   logic [3:0]              uop_rd;
   logic signed [OFF_W-1:0] uop_offset;

   typedef struct packed {
      logic [1:0]       kind;
      logic [3:0]       rd;
      logic [OFF_W-1:0] off;
      logic             last;
      logic             wb;
      logic [31:0]      ins;
   } exp_t;

   exp_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   uop_sequencer dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_instr(uop_instr),
      .uop_kind(uop_kind), .uop_rd(uop_rd), .uop_offset(uop_offset),
      .uop_last(uop_last), .uop_wb(uop_wb), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic expect_uop(input logic [1:0] k, input logic [3:0] rd, input int off,
                             input logic last, input logic wb, input logic [31:0] ins);
      exp_t e;
      e.kind = k; e.rd = rd; e.off = off[OFF_W-1:0];
      e.last = last; e.wb = wb; e.ins = ins;
      exp_q.push_back(e);
   endtask

   task automatic push_ldmia_all();
`ifdef UOPSEQ_WB_UOP_EN
      expect_uop(2'b01, 4'd1, 0, 1'b0, 1'b0, LDMIA);
      expect_uop(2'b01, 4'd3, 4, 1'b0, 1'b0, LDMIA);
      expect_uop(2'b01, 4'd5, 8, 1'b0, 1'b0, LDMIA);
      expect_uop(2'b10, 4'd0, 12, 1'b1, 1'b0, LDMIA);
`else
      expect_uop(2'b01, 4'd1, 0, 1'b0, 1'b0, LDMIA);
      expect_uop(2'b01, 4'd3, 4, 1'b0, 1'b0, LDMIA);
      expect_uop(2'b01, 4'd5, 8, 1'b1, 1'b1, LDMIA);
`endif
   endtask

   // Scoreboard monitor: every handshake must match the head of the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && uop_valid === 1'b1 && uop_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_uop: got kind %0d rd %0d instr %h, required no uop", uop_kind, uop_rd, uop_instr);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("uop_kind",   {30'd0, uop_kind},   {30'd0, e.kind});
               chk("uop_rd",     {28'd0, uop_rd},     {28'd0, e.rd});
               chk("uop_offset", {24'd0, uop_offset}, {24'd0, e.off});
               chk("uop_last",   {31'd0, uop_last},   {31'd0, e.last});
               chk("uop_wb",     {31'd0, uop_wb},     {31'd0, e.wb});
               chk("uop_instr",  uop_instr,           e.ins);
            end
         end
      end
   end

   task automatic send(input logic [31:0] w);
      bit done;
      done = 1'b0;
      @(posedge clk); #1;
      instr = w;
      instr_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (instr_ready) done = 1'b1;
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: instr %h not accepted, required acceptance within 20 cycles", w);
      end
   endtask

   task automatic drain(input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0 && !uop_valid && !busy) done = 1'b1;
      end
      chk({nm, "_drained"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      bit seen;
      reset_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; instr = '0; uop_ready = 1'b1;

      #2;
      chk("rst_uop_valid", {31'd0, uop_valid}, 32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_uop_instr", uop_instr,          32'd0);
      chk("rst_uop_kind",  {30'd0, uop_kind},  32'd0);
      chk("rst_uop_offset",{24'd0, uop_offset},32'd0);
      chk("rst_uop_last",  {31'd0, uop_last},  32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);

      // LDMIA r0!,{r1,r3,r5}
      push_ldmia_all();
      send(LDMIA);
      drain("ldmia");

      // STMDB sp!,{r4,lr}; busy must stay high while the last uop is presented
`ifdef UOPSEQ_WB_UOP_EN
      expect_uop(2'b01, 4'd4,  -8, 1'b0, 1'b0, STMDB);
      expect_uop(2'b01, 4'd14, -4, 1'b0, 1'b0, STMDB);
      expect_uop(2'b10, 4'd0,  -8, 1'b1, 1'b0, STMDB);
`else
      expect_uop(2'b01, 4'd4,  -8, 1'b0, 1'b0, STMDB);
      expect_uop(2'b01, 4'd14, -4, 1'b1, 1'b1, STMDB);
`endif
      send(STMDB);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (uop_valid && uop_last) seen = 1'b1;
      end
      chk("stmdb_last_seen", {31'd0, seen}, 32'd1);
      chk("stmdb_busy_on_last", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("stmdb_busy_after", {31'd0, busy}, 32'd0);
      chk("stmdb_valid_after", {31'd0, uop_valid}, 32'd0);
      drain("stmdb");

      // Backpressure: ADD held for 3 cycles, LDMIA offered behind it
      uop_ready = 1'b0;
      expect_uop(2'b00, 4'd1, 0, 1'b1, 1'b0, ADD);
      push_ldmia_all();
      send(ADD);
      instr = LDMIA;
      instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", {31'd0, uop_valid}, 32'd1);
         chk("bp_hold_instr", uop_instr, ADD);
         chk("bp_hold_rd", {28'd0, uop_rd}, 32'd1);
         chk("bp_instr_ready", {31'd0, instr_ready}, 32'd0);
         @(posedge clk); #1;
      end
      uop_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", {31'd0, instr_ready}, 32'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      chk("bp_seq_instr_ready", {31'd0, instr_ready}, 32'd0);
      chk("bp_seq_busy", {31'd0, busy}, 32'd1);
      drain("backpressure");

      // Flush after rd1 is taken, with an instruction offered in the flush cycle
      expect_uop(2'b01, 4'd1, 0, 1'b0, 1'b0, LDMIA);
      send(LDMIA);
      @(negedge clk);
      chk("fl_first_rd", {28'd0, uop_rd}, 32'd1);
      @(posedge clk); #1;
      uop_ready = 1'b0;
      flush = 1'b1;
      instr = ADD;
      instr_valid = 1'b1;
      @(negedge clk);
      chk("fl_second_rd", {28'd0, uop_rd}, 32'd3);
      chk("fl_instr_ready", {31'd0, instr_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      uop_ready = 1'b1;
      @(negedge clk);
      chk("fl_uop_valid", {31'd0, uop_valid}, 32'd0);
      chk("fl_busy", {31'd0, busy}, 32'd0);
      chk("fl_next_ready", {31'd0, instr_ready}, 32'd1);
      expect_uop(2'b00, 4'd1, 0, 1'b1, 1'b0, ADD);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      chk("fl_next_valid", {31'd0, uop_valid}, 32'd1);
      drain("flush");

      // Empty register list
      expect_uop(2'b11, 4'd0, 0, 1'b1, 1'b0, EMPTY);
      send(EMPTY);
      @(negedge clk);
      chk("empty_busy", {31'd0, busy}, 32'd0);
      drain("empty");

      // Asynchronous reset while the 2nd uop is presented
      expect_uop(2'b01, 4'd1, 0, 1'b0, 1'b0, LDMIA);
      send(LDMIA);
      @(posedge clk); #3;
      chk("rs_mid_rd", {28'd0, uop_rd}, 32'd3);
      reset_n = 1'b0;
      #1;
      chk("rs_uop_valid", {31'd0, uop_valid}, 32'd0);
      chk("rs_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      expect_uop(2'b00, 4'd2, 0, 1'b1, 1'b0, MOV);
      send(MOV);
      @(negedge clk);
      chk("rs_pass_valid", {31'd0, uop_valid}, 32'd1);
      drain("reset");

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
